// File: rtl/xbar_eject_port_pkg.sv
// Shared network definitions: node count, packet format and a saturating
// increment helper used by the eject-port statistics counters.
package xbar_eject_port_pkg;

  localparam int NUM_NODES = 8;
  localparam int NODE_W    = $clog2(NUM_NODES);

  typedef struct packed {
    logic [NODE_W-1:0] src;
    logic [NODE_W-1:0] dest;
    logic [15:0]       payload;
  } pkt_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'h0001;
    end
    return result;
  endfunction

endpackage

// File: rtl/xbar_eject_port_if.sv
// Eject-port bundle: crossbar delivery, core handshake and status outputs.
interface xbar_eject_port_if
  import xbar_eject_port_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  localparam int OCC_W = $clog2(DEPTH) + 1;

  pkt_t             pkt_in;
  logic             pkt_in_valid;
  pkt_t             pkt_out;
  logic             pkt_out_valid;
  logic             pkt_out_ready;
  logic             almost_full;
  logic [OCC_W-1:0] occupancy;
  logic [15:0]      drop_count;
  logic [15:0]      misroute_count;

  modport slave (
    input  pkt_in, pkt_in_valid, pkt_out_ready,
    output pkt_out, pkt_out_valid, almost_full, occupancy, drop_count, misroute_count
  );

  modport master (
    output pkt_in, pkt_in_valid, pkt_out_ready,
    input  pkt_out, pkt_out_valid, almost_full, occupancy, drop_count, misroute_count
  );

endinterface

// File: rtl/xbar_eject_port_sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
module sat_counter16
  import xbar_eject_port_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_d;
  logic [15:0] count_q;

  // next count
  always_comb begin
    if (inc) begin
      count_d = sat_inc16(count_q);
    end else begin
      count_d = count_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= 16'h0000;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/xbar_eject_port.sv
// Crossbar ejection port: a non-stallable ingress feeding a small FIFO to the
// core, with saturating drop and misroute statistics.
module xbar_eject_port
  import xbar_eject_port_pkg::*;
#(
  parameter int NODE_ID = 0,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  xbar_eject_port_if.slave  port
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  pkt_t             mem_d [DEPTH];
  pkt_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [OCC_W-1:0] occ_d, occ_q;

  logic dest_match_s;
  logic not_empty_s;
  logic pop_s;
  logic push_s;
  logic drop_inc_s;
  logic misroute_inc_s;

  // Push is allowed on a full queue when the head leaves in the same cycle,
  // which is why the queue is built inline rather than from a library FIFO.
  always_comb begin
    dest_match_s   = (port.pkt_in.dest == NODE_W'(NODE_ID));
    not_empty_s    = (occ_q != {OCC_W{1'b0}});
    pop_s          = not_empty_s && port.pkt_out_ready;
    push_s         = port.pkt_in_valid && dest_match_s &&
                     ((occ_q < OCC_W'(DEPTH)) || pop_s);
    drop_inc_s     = port.pkt_in_valid && dest_match_s && !push_s;
    misroute_inc_s = port.pkt_in_valid && !dest_match_s;
  end

  // next pointers, occupancy and storage
  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = port.pkt_in;
      wr_ptr_d        = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + {{(OCC_W-1){1'b0}}, 1'b1};
      2'b01:   occ_d = occ_q - {{(OCC_W-1){1'b0}}, 1'b1};
      default: occ_d = occ_q;
    endcase
  end

  // queue state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {OCC_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      mem_q    <= mem_d;
    end
  end

  // Outputs depend on registered state only; an empty queue presents zeros.
  always_comb begin
    port.pkt_out_valid = not_empty_s;
    port.almost_full   = (occ_q >= OCC_W'(DEPTH - 1));
    port.occupancy     = occ_q;
    if (not_empty_s) begin
      port.pkt_out = mem_q[rd_ptr_q];
    end else begin
      port.pkt_out = '0;
    end
  end

  sat_counter16 u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop_inc_s),
    .count (port.drop_count)
  );

  sat_counter16 u_misroute_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (misroute_inc_s),
    .count (port.misroute_count)
  );

endmodule
